// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//   Stopwatch time-keeping core. Keeps an MM:SS count in BCD. The 1 Hz and
//   2 Hz square waves from the clock divider are edge-detected in the clk
//   domain and used as enables only. They are never used as clocks.
//   RUN mode counts seconds with carry into minutes. ADJUST mode steps the
//   selected field at 2 Hz with no carry. The paused flag freezes the count
//   in either mode.
//
// Ports
//   clk          in   100 MHz master clock
//   rst          in   asynchronous, active-high reset
//   onehz_clk    in   1 Hz square wave (clk domain)
//   twohz_clk    in   2 Hz square wave (clk domain)
//   pause_pulse  in   one-clk pulse, toggles paused
//   adj          in   level, 1 = adjust mode
//   sel          in   level, adjust field: 0 = minutes, 1 = seconds
//   min_tens/min_ones/sec_tens/sec_ones  out  BCD digits
//   paused       out  1 = counting frozen
//   blink_field  out  00 none, 01 minutes, 10 seconds
// -----------------------------------------------------------------------------
module stopwatch_counter #(
   parameter int MIN_MAX = 59,
   parameter int SEC_MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       onehz_clk,
   input  logic       twohz_clk,
   input  logic       pause_pulse,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       paused,
   output logic [1:0] blink_field
);

   localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
   localparam logic [3:0] MIN_O = 4'(MIN_MAX % 10);
   localparam logic [3:0] SEC_T = 4'(SEC_MAX / 10);
   localparam logic [3:0] SEC_O = 4'(SEC_MAX % 10);

   typedef enum logic {RUN, ADJUST} mode_e;

   mode_e      mode_q, mode_d;
   logic       sel_q;
   logic       onehz_q, twohz_q;
   logic       paused_q, paused_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic       one_tick, two_tick;

   // A two-digit BCD field steps by one. It wraps to 00 after {max_t,max_o}.
   function automatic logic [7:0] bcd_inc(input logic [7:0] f,
                                          input logic [3:0] max_t,
                                          input logic [3:0] max_o);
      logic [7:0] r;
      if (f[7:4] == max_t && f[3:0] == max_o)
         r = 8'h00;
      else if (f[3:0] == 4'd9)
         r = {f[7:4] + 4'd1, 4'd0};
      else
         r = {f[7:4], f[3:0] + 4'd1};
      return r;
   endfunction

   assign one_tick = onehz_clk & ~onehz_q;
   assign two_tick = twohz_clk & ~twohz_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= RUN;
         sel_q    <= 1'b0;
         onehz_q  <= 1'b0;
         twohz_q  <= 1'b0;
         paused_q <= 1'b0;
         min_q    <= 8'h00;
         sec_q    <= 8'h00;
      end else begin
         mode_q   <= mode_d;
         sel_q    <= sel;
         onehz_q  <= onehz_clk;
         twohz_q  <= twohz_clk;
         paused_q <= paused_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
      end
   end

   // Ticks act on the registered mode, field select and paused values. An
   // adj/sel/pause change in the same cycle as a tick takes effect afterwards.
   always_comb begin
      mode_d   = adj ? ADJUST : RUN;
      paused_d = paused_q ^ pause_pulse;
      min_d    = min_q;
      sec_d    = sec_q;
      if (!paused_q) begin
         if (mode_q == RUN) begin
            if (one_tick) begin
               sec_d = bcd_inc(sec_q, SEC_T, SEC_O);
               if (sec_q == {SEC_T, SEC_O})
                  min_d = bcd_inc(min_q, MIN_T, MIN_O);
            end
         end else begin
            if (two_tick) begin
               if (sel_q)
                  sec_d = bcd_inc(sec_q, SEC_T, SEC_O);
               else
                  min_d = bcd_inc(min_q, MIN_T, MIN_O);
            end
         end
      end
   end

   assign min_tens    = min_q[7:4];
   assign min_ones    = min_q[3:0];
   assign sec_tens    = sec_q[7:4];
   assign sec_ones    = sec_q[3:0];
   assign paused      = paused_q;
   assign blink_field = {(mode_q == ADJUST) & sel_q, (mode_q == ADJUST) & ~sel_q};

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;
   logic       clk = 1'b0;
   logic       rst;
   logic       onehz_clk, twohz_clk, pause_pulse, adj, sel;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       paused;
   logic [1:0] blink_field;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   int   m_min, m_sec;
   bit   m_paused, m_adj, m_sel;
   logic [15:0] sb[$];
   logic [15:0] expd;

   stopwatch_counter #(.MIN_MAX(59), .SEC_MAX(59)) dut (
      .clk(clk), .rst(rst), .onehz_clk(onehz_clk), .twohz_clk(twohz_clk),
      .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .paused(paused), .blink_field(blink_field)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_bcd();
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
   endfunction

   function automatic logic [15:0] dut_digits();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   // One 1 Hz rising edge. The model result goes to the scoreboard.
   task automatic drive_one();
      if (!m_paused && !m_adj) begin
         if (m_sec == 59) begin
            m_sec = 0;
            m_min = (m_min == 59) ? 0 : m_min + 1;
         end else m_sec = m_sec + 1;
      end
      sb.push_back(model_bcd());
      onehz_clk = 1'b1;
      @(negedge clk);
      onehz_clk = 1'b0;
      @(negedge clk);
   endtask

   // One 2 Hz rising edge.
   task automatic drive_two();
      if (!m_paused && m_adj) begin
         if (m_sel) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
         else       m_min = (m_min == 59) ? 0 : m_min + 1;
      end
      sb.push_back(model_bcd());
      twohz_clk = 1'b1;
      @(negedge clk);
      twohz_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic drive_pause();
      m_paused = !m_paused;
      pause_pulse = 1'b1;
      @(negedge clk);
      pause_pulse = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_mode(input bit a, input bit s);
      adj = a; sel = s; m_adj = a; m_sel = s;
      repeat (2) @(negedge clk);
   endtask

   // Preload a time through adjust mode and compare each step.
   task automatic set_time(input int mm, input int ss);
      set_mode(1'b1, 1'b0);
      while (m_min != mm) begin
         drive_two();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL preload_min: got %h expected %h", dut_digits(), expd);
         end
      end
      set_mode(1'b1, 1'b1);
      while (m_sec != ss) begin
         drive_two();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL preload_sec: got %h expected %h", dut_digits(), expd);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; onehz_clk = 0; twohz_clk = 0; pause_pulse = 0; adj = 0; sel = 0;
      m_min = 0; m_sec = 0; m_paused = 0; m_adj = 0; m_sel = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dut_digits(), paused, blink_field} !== 19'h0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0", {dut_digits(), paused, blink_field});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_run_count();
      for (int i = 0; i < 3; i++) begin
         drive_one();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL run_tick%0d: got %h expected %h", i, dut_digits(), expd);
         end
         drive_two();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL run_twohz_ignored%0d: got %h expected %h", i, dut_digits(), expd);
         end
      end
      checks++;
      if (dut_digits() !== 16'h0003) begin
         errors++;
         $display("FAIL run_0003: got %h expected 0003", dut_digits());
      end
   endtask

   task automatic test_carry();
      set_time(0, 59);
      set_mode(1'b0, 1'b0);
      drive_one();
      expd = sb.pop_front();
      checks++;
      if (dut_digits() !== expd || expd !== 16'h0100) begin
         errors++;
         $display("FAIL carry_0100: got %h expected %h", dut_digits(), expd);
      end
      set_time(59, 59);
      set_mode(1'b1, 1'b0);
      drive_one();
      expd = sb.pop_front();
      checks++;
      if (dut_digits() !== expd) begin
         errors++;
         $display("FAIL adjust_onehz_ignored: got %h expected %h", dut_digits(), expd);
      end
      set_mode(1'b0, 1'b0);
      drive_one();
      expd = sb.pop_front();
      checks++;
      if (dut_digits() !== expd || expd !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_5959: got %h expected %h", dut_digits(), expd);
      end
   endtask

   task automatic test_pause();
      set_time(0, 10);
      set_mode(1'b0, 1'b0);
      drive_pause();
      for (int i = 0; i < 5; i++) begin
         drive_one();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL paused_tick%0d: got %h expected %h", i, dut_digits(), expd);
         end
      end
      checks++;
      if (paused !== 1'b1 || dut_digits() !== 16'h0010) begin
         errors++;
         $display("FAIL paused_hold: got %b/%h expected 1/0010", paused, dut_digits());
      end
      drive_pause();
      drive_one();
      expd = sb.pop_front();
      checks++;
      if (dut_digits() !== expd || expd !== 16'h0011 || paused !== 1'b0) begin
         errors++;
         $display("FAIL resume: got %b/%h expected 0/%h", paused, dut_digits(), expd);
      end
   endtask

   task automatic test_adjust();
      set_time(58, 20);
      set_mode(1'b1, 1'b0);
      checks++;
      if (blink_field !== 2'b01) begin
         errors++;
         $display("FAIL blink_min: got %b expected 01", blink_field);
      end
      for (int i = 0; i < 2; i++) begin
         drive_two();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL adj_min%0d: got %h expected %h", i, dut_digits(), expd);
         end
      end
      checks++;
      if (dut_digits() !== 16'h0020) begin
         errors++;
         $display("FAIL adj_min_wrap: got %h expected 0020", dut_digits());
      end
      set_time(0, 58);
      checks++;
      if (blink_field !== 2'b10) begin
         errors++;
         $display("FAIL blink_sec: got %b expected 10", blink_field);
      end
      for (int i = 0; i < 2; i++) begin
         drive_two();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL adj_sec%0d: got %h expected %h", i, dut_digits(), expd);
         end
      end
      checks++;
      if (dut_digits() !== 16'h0000) begin
         errors++;
         $display("FAIL adj_sec_nocarry: got %h expected 0000", dut_digits());
      end
      set_mode(1'b0, 1'b1);
      checks++;
      if (blink_field !== 2'b00) begin
         errors++;
         $display("FAIL blink_run: got %b expected 00", blink_field);
      end
   endtask

   task automatic test_pause_coincident();
      set_time(0, 5);
      set_mode(1'b0, 1'b0);
      // The tick sees the old paused value, so it still counts.
      m_sec = m_sec + 1;
      m_paused = 1'b1;
      onehz_clk = 1'b1; pause_pulse = 1'b1;
      @(negedge clk);
      onehz_clk = 1'b0; pause_pulse = 1'b0;
      @(negedge clk);
      checks++;
      if (dut_digits() !== 16'h0006 || paused !== 1'b1) begin
         errors++;
         $display("FAIL pause_coincident: got %b/%h expected 1/0006", paused, dut_digits());
      end
      for (int i = 0; i < 3; i++) begin
         drive_one();
         expd = sb.pop_front();
         checks++;
         if (dut_digits() !== expd) begin
            errors++;
            $display("FAIL pause_after%0d: got %h expected %h", i, dut_digits(), expd);
         end
      end
   endtask

   task automatic test_async_reset();
      drive_pause();
      set_time(12, 34);
      drive_pause();
      checks++;
      if (dut_digits() !== 16'h1234 || blink_field !== 2'b10 || paused !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got %h/%b/%b expected 1234/10/1", dut_digits(), blink_field, paused);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dut_digits(), paused, blink_field} !== 19'h0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0", {dut_digits(), paused, blink_field});
      end
      m_min = 0; m_sec = 0; m_paused = 0;
      adj = 0; sel = 0; m_adj = 0; m_sel = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive_one();
      expd = sb.pop_front();
      checks++;
      if (dut_digits() !== expd || expd !== 16'h0001) begin
         errors++;
         $display("FAIL post_reset_tick: got %h expected %h", dut_digits(), expd);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_run_count();
      test_carry();
      test_pause();
      test_adjust();
      test_pause_coincident();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
